// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the pipeline MEM stage.
// Accepts one load/store at a time, holds it for WAIT_STATES extra cycles,
// commits it to the internal array, then pulses rsp_valid for one cycle.
// stall holds the pipeline from acceptance until the response cycle.
module dmem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_r;
  logic [3:0]        cnt_r;
  logic              write_r;
  logic [15:0]       addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  logic              commit_s;
  logic              cmt_write_s;
  logic [15:0]       cmt_addr_s;
  logic [DATA_W-1:0] cmt_wdata_s;
  logic [ADDR_W-1:0] idx_s;
  logic              in_range_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              mem_we_s;

  // Stall covers the accept cycle (combinational on req_valid) and all wait cycles.
  assign stall = (state_r == WAIT) | ((state_r == IDLE) & req_valid);

  // Commit decode: with zero wait states the live request commits on its accept edge,
  // otherwise the latched request commits on the last wait cycle.
  always_comb begin
    commit_s    = 1'b0;
    cmt_write_s = write_r;
    cmt_addr_s  = addr_r;
    cmt_wdata_s = wdata_r;
    case (state_r)
      IDLE: begin
        cmt_write_s = req_write;
        cmt_addr_s  = req_addr;
        cmt_wdata_s = req_wdata;
        commit_s    = req_valid & (WAIT_STATES == 0);
      end
      WAIT: begin
        commit_s = (cnt_r == 4'd0);
      end
      default: begin
        commit_s = 1'b0;
      end
    endcase
    idx_s      = cmt_addr_s[ADDR_W-1:0];
    in_range_s = (cmt_addr_s[15:ADDR_W] == {(16-ADDR_W){1'b0}});
    rd_data_s  = mem_r[idx_s];
    // Reset held low must never let a zero-wait store reach the array.
    mem_we_s   = commit_s & cmt_write_s & in_range_s & rst_n;
  end

  // Data array: not reset, written only by an in-range committed store.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= cmt_wdata_s;
    end
  end

  // Control FSM, request latch and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      write_r   <= 1'b0;
      addr_r    <= 16'd0;
      wdata_r   <= {DATA_W{1'b0}};
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= {DATA_W{1'b0}};
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            write_r   <= req_write;
            addr_r    <= req_addr;
            wdata_r   <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_r   <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state_r <= WAIT;
              cnt_r   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          state_r   <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase

      if (commit_s) begin
        if (!in_range_s) begin
          rsp_rdata <= {DATA_W{1'b0}};
          rsp_err   <= 1'b1;
        end else if (cmt_write_s) begin
          rsp_rdata <= {DATA_W{1'b0}};
          rsp_err   <= 1'b0;
        end else begin
          rsp_rdata <= rd_data_s;
          rsp_err   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states and
// one with zero wait states share clock and reset.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v2 = 1'b0, w2 = 1'b0, rr2, rv2, er2, st2;
  logic [15:0] a2 = 16'd0, d2 = 16'd0, rd2;
  logic        v0 = 1'b0, w0 = 1'b0, rr0, rv0, er0, st0;
  logic [15:0] a0 = 16'd0, d0 = 16'd0, rd0;

  dmem_responder #(.DATA_W(16), .ADDR_W(6), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_write(w2), .req_addr(a2),
    .req_wdata(d2), .req_ready(rr2), .rsp_valid(rv2), .rsp_rdata(rd2),
    .rsp_err(er2), .stall(st2));

  dmem_responder #(.DATA_W(16), .ADDR_W(6), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_write(w0), .req_addr(a0),
    .req_wdata(d0), .req_ready(rr0), .rsp_valid(rv0), .rsp_rdata(rd0),
    .rsp_err(er0), .stall(st0));

  typedef struct {
    logic [15:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void cmp_rsp(string tag, logic [15:0] rd, logic err, exp_t e);
    chk({tag, "_rdata"}, int'(rd), int'(e.rd));
    chk({tag, "_err"}, int'(err), int'(e.err));
    chk({tag, "_latency_cycle"}, cyc, e.cyc);
  endfunction

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rv2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL ws2_unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q2.pop_front();
        cmp_rsp("ws2", rd2, er2, e);
      end
    end
    if (rst_n && rv0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL ws0_unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        cmp_rsp("ws0", rd0, er0, e);
      end
    end
  end

  task automatic drive(input int sel, input logic v, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel == 2) begin
      v2 = v; w2 = w; a2 = a; d2 = d;
    end else begin
      v0 = v; w0 = w; a0 = a; d0 = d;
    end
  endtask

  function automatic logic rdy(int sel);
    return (sel == 2) ? rr2 : rr0;
  endfunction

  function automatic logic rspv(int sel);
    return (sel == 2) ? rv2 : rv0;
  endfunction

  function automatic logic stl(int sel);
    return (sel == 2) ? st2 : st0;
  endfunction

  // Issue one request, push its expected response, and count stall cycles.
  // With wiggle set, req_valid stays high and addr/wdata change while waiting.
  task automatic req(input int sel, input logic wr, input logic [15:0] addr,
                     input logic [15:0] wd, input logic [15:0] exp_rd,
                     input logic exp_err, input bit wiggle);
    int n;
    int ws;
    int stall_cnt;
    exp_t e;
    ws = (sel == 2) ? 2 : 0;
    n = 0;
    @(negedge clk);
    while (!rdy(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 (cycle %0d)", cyc);
    end
    drive(sel, 1'b1, wr, addr, wd);
    e.rd = exp_rd; e.err = exp_err; e.cyc = cyc + 1 + ws;
    if (sel == 2) q2.push_back(e); else q0.push_back(e);
    #1;
    stall_cnt = stl(sel) ? 1 : 0;
    @(posedge clk);
    #1;
    if (wiggle) drive(sel, 1'b1, ~wr, addr + 16'd1, ~wd);
    else        drive(sel, 1'b0, 1'b0, 16'd0, 16'd0);
    n = 0;
    @(negedge clk);
    while (!rspv(sel) && n < 40) begin
      if (stl(sel)) stall_cnt++;
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got no rsp_valid expected pulse (cycle %0d)", cyc);
    end
    chk("stall_in_resp", int'(stl(sel)), 0);
    drive(sel, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("stall_cycles", stall_cnt, ws + 1);
  endtask

  initial begin
    // Reset with req_valid high.
    v2 = 1'b1; v0 = 1'b1;
    #12;
    chk("rst_ready", int'(rr2), 1);
    chk("rst_stall", int'(st2), 1);
    chk("rst_rsp_valid", int'(rv2), 0);
    chk("rst_rdata", int'(rd2), 0);
    chk("rst_err", int'(er2), 0);
    chk("rst_ready_ws0", int'(rr0), 1);
    chk("rst_rsp_valid_ws0", int'(rv0), 0);
    @(negedge clk);
    v2 = 1'b0; v0 = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("stall_idle", int'(st2), 0);
    chk("stall_idle_ws0", int'(st0), 0);

    // Two wait states: basic store/load.
    req(2, 1'b1, 16'd5, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    req(2, 1'b0, 16'd5, 16'h0000, 16'hBEEF, 1'b0, 1'b0);

    // Out-of-range store is suppressed.
    req(2, 1'b1, 16'd0,    16'h5A5A, 16'h0000, 1'b0, 1'b0);
    req(2, 1'b1, 16'h0040, 16'h1234, 16'h0000, 1'b1, 1'b0);
    req(2, 1'b0, 16'd0,    16'h0000, 16'h5A5A, 1'b0, 1'b0);
    req(2, 1'b0, 16'hFFC5, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // Inputs changing during WAIT are ignored.
    req(2, 1'b1, 16'd8, 16'h0808, 16'h0000, 1'b0, 1'b0);
    req(2, 1'b1, 16'd7, 16'hCAFE, 16'h0000, 1'b0, 1'b1);
    req(2, 1'b0, 16'd7, 16'h0000, 16'hCAFE, 1'b0, 1'b0);
    req(2, 1'b0, 16'd8, 16'h0000, 16'h0808, 1'b0, 1'b0);

    // Reset during WAIT abandons the store.
    req(2, 1'b1, 16'd3, 16'h1111, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 16'd3, 16'hAAAA);
    @(posedge clk);
    #1;
    drive(2, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", int'(rv2), 0);
    chk("abort_ready", int'(rr2), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    req(2, 1'b0, 16'd3, 16'h0000, 16'h1111, 1'b0, 1'b0);

    // Zero wait states: back-to-back store/load to the top address.
    req(0, 1'b1, 16'd63, 16'hF00D, 16'h0000, 1'b0, 1'b0);
    req(0, 1'b0, 16'd63, 16'h0000, 16'hF00D, 1'b0, 1'b0);
    req(0, 1'b1, 16'h007F, 16'h9999, 16'h0000, 1'b1, 1'b0);
    req(0, 1'b0, 16'd63, 16'h0000, 16'hF00D, 1'b0, 1'b0);

    repeat (6) @(negedge clk);
    chk("ws2_queue_drained", q2.size(), 0);
    chk("ws0_queue_drained", q0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's data-memory port. It accepts one load or store request at a time from the MEM stage and models a configurable number of wait states. While an access is in flight it drives a stall back to the pipeline, then returns read data or a write acknowledgement with a one-cycle response pulse. It holds the 16-bit data array and replaces the single-cycle data memory when multi-cycle memory timing must be exercised.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 6, word-address bits; array depth is 2**ADDR_W words
- WAIT_STATES, 2, extra cycles between request acceptance and commit; legal range 0..15
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  MEM stage presents a request (memread or memwrite asserted)
- req_write  input  1  1 = store, 0 = load; sampled at acceptance
- req_addr  input  16  word address (ALU result); sampled at acceptance
- req_wdata  input  DATA_W  store data; sampled at acceptance
- req_ready  output  1  responder can accept a request this cycle
- rsp_valid  output  1  one-cycle pulse: access completed
- rsp_rdata  output  DATA_W  load data; valid with rsp_valid, held until the next response
- rsp_err  output  1  address out of range; valid with rsp_valid
- stall  output  1  pipeline must hold the MEM stage and all earlier stages

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On a rising edge with req_valid=1, the block latches write, addr and wdata.
  - WAIT_STATES=0: the access commits on this edge and the FSM goes to RESP.
  - Otherwise the FSM goes to WAIT with cnt=WAIT_STATES-1.
- WAIT: req_ready=0; request inputs are ignored.
  - If cnt==0, the access commits on the edge and the FSM goes to RESP.
  - Otherwise cnt decrements.
- RESP: rsp_valid=1, req_ready=0. The FSM returns to IDLE unconditionally on the next edge.
- Commit, in-range access (latched addr[15:ADDR_W]==0):
  - Store: mem[addr[ADDR_W-1:0]] <= wdata; rsp_rdata <= 0.
  - Load: rsp_rdata <= mem[addr]; rsp_err <= 0.
- Commit, out-of-range access: the store is suppressed, rsp_rdata <= 0, rsp_err <= 1.
- stall = (state==WAIT) | (state==IDLE & req_valid). It is 0 in RESP, so the pipeline advances on the edge that ends RESP and captures rsp_rdata.
- A load following a store to the same address returns the new data, because the store commits before the load is accepted.
- Requests that arrive during WAIT or RESP are not queued. The pipeline is stalled, so the same request is still present when the FSM re-enters IDLE.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1.
  - stall follows req_valid combinationally.
  - Array contents are not affected by reset.
- Reset asserted before the commit edge abandons the access: no array write, no response.
- Latency: the request is accepted at edge E0, and rsp_valid is high during cycle WAIT_STATES+1 after E0.
- Throughput: one access per WAIT_STATES+2 cycles.
- Back-to-back requests: the next request can be accepted at the edge that ends RESP+1, i.e. the first cycle back in IDLE.
- No combinational path from req_* to rsp_*. The only combinational input-to-output path is req_valid to stall.
- cnt width is 4 bits.

## Test plan
- Reset: hold rst_n=0 with req_valid=1 -> req_ready=1, stall=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Release with req_valid=0 -> stall=0.
- Store/load, WAIT_STATES=2:
  - Store 0xBEEF to address 5 -> rsp_valid pulses 3 cycles after acceptance, rsp_err=0, stall high for 3 cycles.
  - Then load address 5 -> rsp_rdata=0xBEEF, rsp_valid 3 cycles after acceptance.
- WAIT_STATES=0: load immediately after store to address 63 -> rsp_valid 1 cycle after each acceptance, and the load returns the stored value.
- Out of range: store 0x1234 to address 0x0040 -> rsp_err=1, rsp_rdata=0. A following load of address 0 returns its prior contents, proving the write was suppressed.
- Input change during WAIT: change req_addr and req_wdata mid-access -> the originally latched address and data are used, and there is exactly one rsp_valid pulse.
- Reset mid-access: store 0xAAAA to address 3, then assert rst_n=0 during WAIT -> no rsp_valid, and a later load of address 3 returns its prior value.
